// File: rtl/sram_rmw_ctrl.sv
// ---------------------------------------------------------------------------
// sram_rmw_ctrl
//
// Request front-end for a single-port SRAM whose macros have no byte enables.
// Requests arrive on a valid/ready channel and are issued to the SRAM in
// strict accept order. Read data returns on a valid/ready response channel
// through a small FIFO that absorbs the SRAM's one-cycle read latency under
// backpressure. A write with a partial byte-enable mask becomes an atomic
// read-modify-write: the word is read in the accept cycle and the merged word
// is written back in the following cycle.
//
// Ports
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   req_valid_i/req_ready_o  request handshake
//   req_we_i, req_addr_i,    request: write flag, word address,
//   req_wdata_i, req_be_i    write data, byte enables
//   rsp_valid_o/rsp_ready_i  response handshake
//   rsp_rdata_o              read data, in request order
//   sram_req_o, sram_we_o,   SRAM chip enable, write enable,
//   sram_addr_o, sram_wdata_o address, full-word write data
//   sram_be_o                SRAM byte enables, always all-ones
//   sram_rdata_i             SRAM read data, one cycle after a read
//   busy_o                   RMW pending, read in flight or FIFO non-empty
// ---------------------------------------------------------------------------
module sram_rmw_ctrl #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_WORDS  = 256,
  parameter int RSP_DEPTH  = 2,
  localparam int BW = (DATA_WIDTH + 7) / 8,
  localparam int AW = $clog2(NUM_WORDS)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [AW-1:0]         req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  input  logic [BW-1:0]         req_be_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  sram_req_o,
  output logic                  sram_we_o,
  output logic [AW-1:0]         sram_addr_o,
  output logic [DATA_WIDTH-1:0] sram_wdata_o,
  output logic [BW-1:0]         sram_be_o,
  input  logic [DATA_WIDTH-1:0] sram_rdata_i,
  output logic                  busy_o
);

  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CW = $clog2(RSP_DEPTH + 1);

  typedef enum logic {IDLE = 1'b0, RMW_WR = 1'b1} state_e;

  state_e                state_q, state_d;
  logic                  rd_inflight_q, rd_inflight_d;
  logic [AW-1:0]         rmw_addr_q, rmw_addr_d;
  logic [DATA_WIDTH-1:0] rmw_wdata_q, rmw_wdata_d;
  logic [BW-1:0]         rmw_be_q, rmw_be_d;
  logic [DATA_WIDTH-1:0] fifo_q [RSP_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_d [RSP_DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;

  logic                  rd_credit;
  logic                  accept;
  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] merged;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
    if (ptr == PW'(RSP_DEPTH - 1)) return '0;
    return ptr + 1'b1;
  endfunction

  // A read only gets credit if its data has a guaranteed FIFO slot; a pop in
  // the same cycle is deliberately not counted so ready never depends on
  // rsp_ready_i. Writes produce no response and ignore FIFO space.
  assign rd_credit   = (int'(count_q) + int'(rd_inflight_q)) < RSP_DEPTH;
  assign req_ready_o = rst_ni && (state_q == IDLE) && (req_we_i || rd_credit);
  assign accept      = req_valid_i && req_ready_o;

  assign push        = rd_inflight_q;
  assign pop         = (count_q != '0) && rsp_ready_i;
  assign rsp_valid_o = (count_q != '0);
  assign rsp_rdata_o = fifo_q[rd_ptr_q];
  assign sram_be_o   = '1;
  assign busy_o      = (state_q != IDLE) || rd_inflight_q || (count_q != '0);

  // Byte merge for the write-back half of an RMW; works bit by bit so a
  // DATA_WIDTH that is not a multiple of 8 still maps onto its last byte lane.
  always_comb begin
    merged = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      merged[i] = rmw_be_q[i / 8] ? rmw_wdata_q[i] : sram_rdata_i[i];
    end
  end

  // Request FSM: SRAM access is combinational in the accept cycle. The read
  // half of an RMW leaves rd_inflight clear so its data never reaches the FIFO.
  always_comb begin
    state_d       = state_q;
    rd_inflight_d = 1'b0;
    rmw_addr_d    = rmw_addr_q;
    rmw_wdata_d   = rmw_wdata_q;
    rmw_be_d      = rmw_be_q;
    sram_req_o    = 1'b0;
    sram_we_o     = 1'b0;
    sram_addr_o   = req_addr_i;
    sram_wdata_o  = req_wdata_i;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (!req_we_i) begin
            sram_req_o    = 1'b1;
            rd_inflight_d = 1'b1;
          end else if (&req_be_i) begin
            sram_req_o = 1'b1;
            sram_we_o  = 1'b1;
          end else if (|req_be_i) begin
            sram_req_o  = 1'b1;
            rmw_addr_d  = req_addr_i;
            rmw_wdata_d = req_wdata_i;
            rmw_be_d    = req_be_i;
            state_d     = RMW_WR;
          end
        end
      end
      RMW_WR: begin
        sram_req_o   = 1'b1;
        sram_we_o    = 1'b1;
        sram_addr_o  = rmw_addr_q;
        sram_wdata_o = merged;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Response FIFO bookkeeping; push while full is impossible because read
  // credit accounts for the in-flight read, so push+pop when full keeps count.
  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      fifo_d[wr_ptr_q] = sram_rdata_i;
      wr_ptr_d         = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // State registers; reset abandons any pending RMW write-back and flushes
  // the response FIFO.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      rd_inflight_q <= 1'b0;
      rmw_addr_q    <= '0;
      rmw_wdata_q   <= '0;
      rmw_be_q      <= '0;
      fifo_q        <= '{default: '0};
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      rd_inflight_q <= rd_inflight_d;
      rmw_addr_q    <= rmw_addr_d;
      rmw_wdata_q   <= rmw_wdata_d;
      rmw_be_q      <= rmw_be_d;
      fifo_q        <= fifo_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
    end
  end

endmodule

// File: tb/tb_sram_rmw_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sram_rmw_ctrl
//
// Self-checking bench for sram_rmw_ctrl. A behavioural SRAM sits behind the
// DUT. A reference model keeps the architectural memory contents as a plain
// array updated at request-accept time and an ordered queue of expected read
// responses. Directed scenarios cover the reset state, posted writes, RMW,
// backpressure, empty byte masks and reset during RMW; a randomized phase
// then mixes all request kinds with random response backpressure.
// ---------------------------------------------------------------------------
module tb_sram_rmw_ctrl;

  logic        clk;
  logic        rstN;
  logic        reqValid;
  logic        reqReady;
  logic        reqWe;
  logic [7:0]  reqAddr;
  logic [63:0] reqWdata;
  logic [7:0]  reqBe;
  logic        rspValid;
  logic        rspReady;
  logic [63:0] rspRdata;
  logic        sramReq;
  logic        sramWe;
  logic [7:0]  sramAddr;
  logic [63:0] sramWdata;
  logic [7:0]  sramBe;
  logic [63:0] sramRdata;
  logic        busy;

  logic [63:0] sramMem [256];
  logic [63:0] refMem [256];
  logic [63:0] expQ [$];

  int checks;
  int errors;
  int rspSeen;

  logic        accSramReq;
  logic        accSramWe;
  logic [7:0]  accSramAddr;
  logic [63:0] accSramWdata;

  sram_rmw_ctrl #(
    .DATA_WIDTH(64),
    .NUM_WORDS (256),
    .RSP_DEPTH (2)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rstN),
    .req_valid_i (reqValid),
    .req_ready_o (reqReady),
    .req_we_i    (reqWe),
    .req_addr_i  (reqAddr),
    .req_wdata_i (reqWdata),
    .req_be_i    (reqBe),
    .rsp_valid_o (rspValid),
    .rsp_ready_i (rspReady),
    .rsp_rdata_o (rspRdata),
    .sram_req_o  (sramReq),
    .sram_we_o   (sramWe),
    .sram_addr_o (sramAddr),
    .sram_wdata_o(sramWdata),
    .sram_be_o   (sramBe),
    .sram_rdata_i(sramRdata),
    .busy_o      (busy)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural single-port SRAM with one-cycle registered read data.
  always @(posedge clk) begin
    if (sramReq) begin
      if (sramWe) sramMem[sramAddr] <= sramWdata;
      else sramRdata <= sramMem[sramAddr];
    end
  end

  // Byte-lane merge as the architecture defines a masked write.
  function automatic logic [63:0] mergeWord(input logic [63:0] oldWord,
                                            input logic [63:0] newWord,
                                            input logic [7:0] be);
    logic [63:0] res;
    for (int b = 0; b < 8; b++) begin
      res[b*8 +: 8] = be[b] ? newWord[b*8 +: 8] : oldWord[b*8 +: 8];
    end
    return res;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Reference model, evaluated at every falling edge where all handshake
  // signals are stable: accepted requests update memory or queue an expected
  // response, consumed responses are compared in order, and a stalled head
  // must hold its data.
  task automatic monitorLoop();
    logic        stallPrev;
    logic [63:0] dataPrev;
    logic [63:0] expWord;
    stallPrev = 1'b0;
    dataPrev  = '0;
    forever begin
      @(negedge clk);
      if (!rstN) begin
        expQ.delete();
        stallPrev = 1'b0;
      end else begin
        if (stallPrev) begin
          checkOutput("rsp_hold_valid", 64'(rspValid), 64'd1);
          checkOutput("rsp_hold_data", rspRdata, dataPrev);
        end
        if (rspValid && rspReady) begin
          if (expQ.size() == 0) begin
            checkOutput("rsp_unexpected", 64'd1, 64'd0);
          end else begin
            expWord = expQ.pop_front();
            checkOutput("rsp_data", rspRdata, expWord);
            rspSeen++;
          end
        end
        stallPrev = rspValid && !rspReady;
        dataPrev  = rspRdata;
        if (reqValid && reqReady) begin
          if (!reqWe) expQ.push_back(refMem[reqAddr]);
          else refMem[reqAddr] = mergeWord(refMem[reqAddr], reqWdata, reqBe);
        end
      end
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Offer one request starting just after a rising edge and hold it until
  // accepted; returns just after the accepting edge with valid dropped.
  // A long stall releases response backpressure so reads cannot deadlock.
  task automatic applyStimulus(input logic we, input logic [7:0] addr,
                               input logic [63:0] wdata, input logic [7:0] be,
                               output int waits);
    reqValid = 1'b1;
    reqWe    = we;
    reqAddr  = addr;
    reqWdata = wdata;
    reqBe    = be;
    waits    = 0;
    forever begin
      @(negedge clk);
      if (reqReady) break;
      waits++;
      if (waits > 50) begin
        checkOutput("accept_timeout", 64'd0, 64'd1);
        break;
      end
      @(posedge clk);
      #1;
      if (waits >= 3) rspReady = 1'b1;
    end
    accSramReq   = sramReq;
    accSramWe    = sramWe;
    accSramAddr  = sramAddr;
    accSramWdata = sramWdata;
    @(posedge clk);
    #1;
    reqValid = 1'b0;
  endtask

  // Single read with an empty FIFO: data must appear exactly one cycle after
  // the accepting edge.
  task automatic readCheck(input logic [7:0] addr, input logic [63:0] expWord,
                           input string tag, output int waits);
    applyStimulus(1'b0, addr, 64'd0, 8'h00, waits);
    @(negedge clk);
    checkOutput({tag, "_lat0"}, 64'(rspValid), 64'd0);
    @(negedge clk);
    checkOutput({tag, "_valid"}, 64'(rspValid), 64'd1);
    checkOutput({tag, "_rdata"}, rspRdata, expWord);
    nextCycle();
  endtask

  task automatic drainAll();
    rspReady = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy && expQ.size() == 0) break;
    end
    checkOutput("drain_busy", 64'(busy), 64'd0);
    checkOutput("drain_queue", 64'(expQ.size()), 64'd0);
    nextCycle();
  endtask

  // Main sequence: reset, preload, directed scenarios, random mix, final
  // memory comparison and summary.
  initial begin
    int          w;
    int          seenBefore;
    int          kind;
    logic [7:0]  rAddr;
    logic [63:0] rData;
    logic [7:0]  rBe;
    logic [63:0] oldWord;

    checks   = 0;
    errors   = 0;
    rspSeen  = 0;
    rstN     = 1'b0;
    reqValid = 1'b1;
    reqWe    = 1'b0;
    reqAddr  = '0;
    reqWdata = '0;
    reqBe    = '0;
    rspReady = 1'b1;

    fork
      monitorLoop();
    join_none

    repeat (2) @(negedge clk);
    checkOutput("reset_req_ready", 64'(reqReady), 64'd0);
    checkOutput("reset_sram_req", 64'(sramReq), 64'd0);
    checkOutput("reset_rsp_valid", 64'(rspValid), 64'd0);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("sram_be_ones", 64'(sramBe), 64'hFF);
    nextCycle();
    rstN     = 1'b1;
    reqValid = 1'b0;

    for (int a = 0; a < 32; a++) begin
      applyStimulus(1'b1, 8'(a), {$urandom, $urandom}, 8'hFF, w);
    end

    $display("[TB] scenario 1: full write then read");
    applyStimulus(1'b1, 8'd5, 64'h1122334455667788, 8'hFF, w);
    checkOutput("t1_accept_wait", 64'(w), 64'd0);
    checkOutput("t1_sram_req", 64'(accSramReq), 64'd1);
    checkOutput("t1_sram_we", 64'(accSramWe), 64'd1);
    checkOutput("t1_sram_addr", 64'(accSramAddr), 64'd5);
    checkOutput("t1_sram_wdata", accSramWdata, 64'h1122334455667788);
    @(negedge clk);
    checkOutput("t1_we_one_cycle", 64'(sramReq), 64'd0);
    checkOutput("t1_no_rsp", 64'(rspValid), 64'd0);
    nextCycle();
    readCheck(8'd5, 64'h1122334455667788, "t1_read", w);

    $display("[TB] scenario 2: partial write becomes RMW");
    applyStimulus(1'b1, 8'd7, 64'hFFFFFFFFFFFFFFFF, 8'hFF, w);
    applyStimulus(1'b1, 8'd7, 64'h00000000000000AB, 8'h01, w);
    checkOutput("t2_rmw_rd_req", 64'(accSramReq), 64'd1);
    checkOutput("t2_rmw_rd_we", 64'(accSramWe), 64'd0);
    checkOutput("t2_rmw_rd_addr", 64'(accSramAddr), 64'd7);
    @(negedge clk);
    checkOutput("t2_ready_low", 64'(reqReady), 64'd0);
    checkOutput("t2_wr_req", 64'(sramReq), 64'd1);
    checkOutput("t2_wr_we", 64'(sramWe), 64'd1);
    checkOutput("t2_wr_addr", 64'(sramAddr), 64'd7);
    checkOutput("t2_wr_data", sramWdata, 64'hFFFFFFFFFFFFFFAB);
    nextCycle();
    checkOutput("t2_ready_back", 64'(reqReady), 64'd1);
    checkOutput("t2_idle_sram", 64'(sramReq), 64'd0);
    checkOutput("t2_no_rsp", 64'(rspValid), 64'd0);
    checkOutput("t2_not_busy", 64'(busy), 64'd0);
    readCheck(8'd7, 64'hFFFFFFFFFFFFFFAB, "t2_read", w);

    $display("[TB] scenario 3: response backpressure");
    seenBefore = rspSeen;
    rspReady = 1'b0;
    reqValid = 1'b1;
    reqWe    = 1'b0;
    reqAddr  = 8'd10;
    @(negedge clk);
    checkOutput("t3_rd0_ready", 64'(reqReady), 64'd1);
    nextCycle();
    reqAddr = 8'd11;
    @(negedge clk);
    checkOutput("t3_rd1_ready", 64'(reqReady), 64'd1);
    nextCycle();
    reqAddr = 8'd12;
    @(negedge clk);
    checkOutput("t3_rd2_blocked", 64'(reqReady), 64'd0);
    nextCycle();
    @(negedge clk);
    checkOutput("t3_rd2_still_blocked", 64'(reqReady), 64'd0);
    checkOutput("t3_fifo_full_valid", 64'(rspValid), 64'd1);
    nextCycle();
    reqValid = 1'b0;
    applyStimulus(1'b1, 8'd20, {$urandom, $urandom}, 8'hFF, w);
    checkOutput("t3_write_while_full", 64'(w), 64'd0);
    rspReady = 1'b1;
    applyStimulus(1'b0, 8'd12, 64'd0, 8'h00, w);
    checkOutput("t3_pop_no_credit", 64'(w), 64'd1);
    applyStimulus(1'b0, 8'd13, 64'd0, 8'h00, w);
    drainAll();
    checkOutput("t3_rsp_count", 64'(rspSeen - seenBefore), 64'd4);

    $display("[TB] scenario 4: empty byte mask");
    applyStimulus(1'b1, 8'd30, {$urandom, $urandom}, 8'h00, w);
    checkOutput("t4_accept_wait", 64'(w), 64'd0);
    checkOutput("t4_no_sram", 64'(accSramReq), 64'd0);
    @(negedge clk);
    checkOutput("t4_no_sram_after", 64'(sramReq), 64'd0);
    checkOutput("t4_no_rsp", 64'(rspValid), 64'd0);
    checkOutput("t4_not_busy", 64'(busy), 64'd0);
    nextCycle();

    $display("[TB] scenario 5: reset during RMW write-back");
    oldWord = refMem[9];
    applyStimulus(1'b1, 8'd9, {$urandom, $urandom}, 8'h0F, w);
    checkOutput("t5_busy_rmw", 64'(busy), 64'd1);
    checkOutput("t5_rmw_we", 64'(sramWe), 64'd1);
    rstN = 1'b0;
    #1;
    checkOutput("t5_rst_busy", 64'(busy), 64'd0);
    checkOutput("t5_rst_rsp_valid", 64'(rspValid), 64'd0);
    checkOutput("t5_rst_sram_req", 64'(sramReq), 64'd0);
    checkOutput("t5_rst_ready", 64'(reqReady), 64'd0);
    nextCycle();
    rstN = 1'b1;
    @(negedge clk);
    checkOutput("t5_word_kept", sramMem[9], oldWord);
    refMem[9] = oldWord;
    nextCycle();
    readCheck(8'd9, oldWord, "t5_read", w);

    $display("[TB] scenario 6: read right behind partial write");
    applyStimulus(1'b1, 8'd3, 64'h0123456789ABCDEF, 8'hFF, w);
    applyStimulus(1'b1, 8'd3, 64'hAAAAAAAABBBBBBBB, 8'hF0, w);
    readCheck(8'd3, 64'hAAAAAAAA89ABCDEF, "t6_read", w);
    checkOutput("t6_stall_cycles", 64'(w), 64'd1);

    $display("[TB] random phase");
    for (int n = 0; n < 300; n++) begin
      kind     = $urandom_range(0, 99);
      rspReady = ($urandom_range(0, 3) != 0);
      rAddr    = 8'($urandom_range(0, 15));
      rData    = {$urandom, $urandom};
      if (kind < 40) begin
        applyStimulus(1'b0, rAddr, rData, 8'h00, w);
      end else if (kind < 60) begin
        applyStimulus(1'b1, rAddr, rData, 8'hFF, w);
      end else if (kind < 85) begin
        rBe = 8'($urandom_range(1, 254));
        applyStimulus(1'b1, rAddr, rData, rBe, w);
      end else begin
        applyStimulus(1'b1, rAddr, rData, 8'h00, w);
      end
      repeat ($urandom_range(0, 2)) nextCycle();
    end
    drainAll();

    for (int a = 0; a < 32; a++) begin
      checkOutput("mem_final", sramMem[a], refMem[a]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
